wino_stream_ctrl: RTL and testbench

WINO_STREAM_CTRL -- requirements
Module: wino_stream_ctrl

---
 rtl/wino_stream_ctrl.sv | 91 +++++++++
 tb/tb_wino_stream_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wino_stream_ctrl.sv
// Collects eight (a,b) operand beats for a winograd core, waits the fixed core latency,
// then holds the summed core result until the consumer takes it.
module wino_stream_ctrl #(
   parameter  int IN_SIZE_0 = 8,
   parameter  int IN_SIZE_1 = 8,
   parameter  int CORE_LAT  = 3,
   localparam int OUT_SIZE  = ((IN_SIZE_1 + 1) * 2) + 6
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [IN_SIZE_0-1:0]           in_a_i,
   input  logic [IN_SIZE_1-1:0]           in_b_i,
   output logic [7:0][IN_SIZE_0-1:0]      core_in_0_o,
   output logic [7:0][IN_SIZE_1-1:0]      core_in_1_o,
   input  logic [1:0][OUT_SIZE-1:0]       core_out_i,
   output logic                           res_valid_o,
   input  logic                           res_ready_i,
   output logic [OUT_SIZE-1:0]            res_o
);

   typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

   state_t                      state_q;
   logic [2:0]                  beat_cnt_q;
   logic [3:0]                  lat_cnt_q;
   logic [7:0][IN_SIZE_0-1:0]   op0_q;
   logic [7:0][IN_SIZE_1-1:0]   op1_q;
   logic [OUT_SIZE-1:0]         res_q;
   logic                        res_valid_q;
   logic                        in_ready_q;
   logic [OUT_SIZE-1:0]         sum_d;

   // Two's-complement add at OUT_SIZE bits wraps without saturation.
   assign sum_d = core_out_i[0] + core_out_i[1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= FILL;
         beat_cnt_q  <= 3'd0;
         lat_cnt_q   <= 4'd0;
         op0_q       <= '0;
         op1_q       <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            FILL: begin
               if (in_valid_i) begin
                  op0_q[beat_cnt_q] <= in_a_i;
                  op1_q[beat_cnt_q] <= in_b_i;
                  beat_cnt_q        <= beat_cnt_q + 3'd1;
                  if (beat_cnt_q == 3'd7) begin
                     lat_cnt_q  <= 4'(CORE_LAT);
                     in_ready_q <= 1'b0;
                     state_q    <= WAIT;
                  end
               end
            end
            WAIT: begin
               lat_cnt_q <= lat_cnt_q - 4'd1;
               // Last latency cycle: core output is settled on this edge.
               if (lat_cnt_q == 4'd1) begin
                  res_q       <= sum_d;
                  res_valid_q <= 1'b1;
                  state_q     <= DRAIN;
               end
            end
            DRAIN: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= FILL;
               end
            end
            default: begin
               state_q <= FILL;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign res_valid_o = res_valid_q;
   assign res_o       = res_q;
   assign core_in_0_o = op0_q;
   assign core_in_1_o = op1_q;

endmodule

// File: tb/tb_wino_stream_ctrl.sv
// Directed and randomized bench for wino_stream_ctrl with a combinational winograd core model.
module tb_wino_stream_ctrl;

   localparam int OW = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic res_ready = 1'b1;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic core_force = 1'b0;
   logic [OW-1:0] f0 = '0;
   logic [OW-1:0] f1 = '0;

   logic in_ready_m, res_valid_m, in_ready_1, res_valid_1, in_ready_5, res_valid_5;
   logic [OW-1:0] res_m, res_1, res_5;
   logic [7:0][7:0] ci0_m, ci1_m, ci0_1, ci1_1, ci0_5, ci1_5;
   logic [1:0][OW-1:0] co_m, co_1, co_5;

   int checks = 0;
   int errors = 0;
   int lat_n;
   bit ready_bad;

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] sx(input logic [7:0] v);
      return {{(OW-8){v[7]}}, v};
   endfunction

   function automatic logic [OW-1:0] term(input logic [7:0] a_lo, a_hi, b_lo, b_hi);
      return (sx(a_hi) + sx(b_lo)) * (sx(a_lo) + sx(b_hi));
   endfunction

   function automatic logic [OW-1:0] psum(input logic [7:0][7:0] a, b, input int base);
      return term(a[base], a[base+1], b[base], b[base+1])
           + term(a[base+2], a[base+3], b[base+2], b[base+3]);
   endfunction

   always_comb begin
      co_m[0] = core_force ? f0 : psum(ci0_m, ci1_m, 0);
      co_m[1] = core_force ? f1 : psum(ci0_m, ci1_m, 4);
   end
   assign co_1 = {psum(ci0_1, ci1_1, 4), psum(ci0_1, ci1_1, 0)};
   assign co_5 = {psum(ci0_5, ci1_5, 4), psum(ci0_5, ci1_5, 0)};

   wino_stream_ctrl #(.IN_SIZE_0(8), .IN_SIZE_1(8), .CORE_LAT(3)) dut_m (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
      .in_a_i(in_a), .in_b_i(in_b), .core_in_0_o(ci0_m), .core_in_1_o(ci1_m),
      .core_out_i(co_m), .res_valid_o(res_valid_m), .res_ready_i(res_ready), .res_o(res_m));

   wino_stream_ctrl #(.IN_SIZE_0(8), .IN_SIZE_1(8), .CORE_LAT(1)) dut_1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_1),
      .in_a_i(in_a), .in_b_i(in_b), .core_in_0_o(ci0_1), .core_in_1_o(ci1_1),
      .core_out_i(co_1), .res_valid_o(res_valid_1), .res_ready_i(res_ready), .res_o(res_1));

   wino_stream_ctrl #(.IN_SIZE_0(8), .IN_SIZE_1(8), .CORE_LAT(5)) dut_5 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_5),
      .in_a_i(in_a), .in_b_i(in_b), .core_in_0_o(ci0_5), .core_in_1_o(ci1_5),
      .core_out_i(co_5), .res_valid_o(res_valid_5), .res_ready_i(res_ready), .res_o(res_5));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input int gap);
      int guard;
      in_valid = 1'b0;
      repeat (gap) step();
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      guard = 0;
      while (!in_ready_m && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout in_ready stayed %0b, want 1", in_ready_m);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [7:0][7:0] a, input logic [7:0][7:0] b, input int max_gap);
      for (int i = 0; i < 8; i++)
         send_beat(a[i], b[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
   endtask

   task automatic wait_result();
      lat_n = 0;
      ready_bad = 1'b0;
      while (!res_valid_m && lat_n < 40) begin
         if (in_ready_m) ready_bad = 1'b1;
         step();
         lat_n++;
      end
      if (in_ready_m) ready_bad = 1'b1;
      if (lat_n >= 40) begin
         checks++;
         errors++;
         $display("FAIL result_timeout res_valid %0b after %0d cycles", res_valid_m, lat_n);
      end
   endtask

   task automatic fill_vec(output logic [7:0][7:0] a, output logic [7:0][7:0] b,
                           input logic [7:0] av, input logic [7:0] bv);
      for (int i = 0; i < 8; i++) begin
         a[i] = av;
         b[i] = bv;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready_m); end
      checks++; if (res_valid_m !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %0b want 0", res_valid_m); end
      checks++; if (res_m !== '0) begin errors++; $display("FAIL rst_res got %0h want 0", res_m); end
      checks++; if (ci0_m !== '0) begin errors++; $display("FAIL rst_core_in_0 got %0h want 0", ci0_m); end
      checks++; if (ci1_m !== '0) begin errors++; $display("FAIL rst_core_in_1 got %0h want 0", ci1_m); end
   endtask

   task automatic run_directed(input string name, input logic [7:0] av, input logic [7:0] bv,
                               input logic [OW-1:0] exp);
      logic [7:0][7:0] va, vb;
      fill_vec(va, vb, av, bv);
      res_ready = 1'b1;
      send_vec(va, vb, 0);
      wait_result();
      checks++; if (lat_n != 3) begin errors++; $display("FAIL %s_latency got %0d want 3", name, lat_n); end
      checks++; if (res_m !== exp) begin errors++; $display("FAIL %s_res got %0h want %0h", name, res_m, exp); end
      checks++; if (ready_bad) begin errors++; $display("FAIL %s_ready_in_wait got 1 want 0", name); end
      step();
   endtask

   task automatic test_ones();
      run_directed("ones", 8'd1, 8'd1, 24'd16);
      checks++; if (res_valid_m !== 1'b0) begin errors++; $display("FAIL ones_drain_clear got %0b want 0", res_valid_m); end
      checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL ones_refill got %0b want 1", in_ready_m); end
   endtask

   task automatic test_neg();
      run_directed("neg1", 8'hFF, 8'h00, 24'd4);
      run_directed("min", 8'h80, 8'h80, 24'h040000);
   endtask

   task automatic test_wrap();
      core_force = 1'b1;
      f0 = 24'h7FFFFF;
      f1 = 24'h000001;
      run_directed("wrap_pos", 8'd3, 8'd4, 24'h800000);
      f0 = 24'h800000;
      f1 = 24'hFFFFFF;
      run_directed("wrap_neg", 8'd3, 8'd4, 24'h7FFFFF);
      core_force = 1'b0;
   endtask

   task automatic test_fill_hold();
      logic [7:0][7:0] e0, e1;
      pulse_reset();
      e0 = '0;
      e1 = '0;
      e0[0] = 8'd5; e0[1] = 8'd6; e0[2] = 8'd7;
      e1[0] = 8'd1; e1[1] = 8'd2; e1[2] = 8'd3;
      for (int i = 0; i < 3; i++) send_beat(e0[i], e1[i], 0);
      repeat (6) step();
      checks++; if (ci0_m !== e0) begin errors++; $display("FAIL idle_core_in_0 got %0h want %0h", ci0_m, e0); end
      checks++; if (ci1_m !== e1) begin errors++; $display("FAIL idle_core_in_1 got %0h want %0h", ci1_m, e1); end
      checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b want 1", in_ready_m); end
      for (int i = 3; i < 8; i++) send_beat(8'd0, 8'd0, 1);
      wait_result();
      checks++; if (res_m !== 24'd70) begin errors++; $display("FAIL gap_res got %0h want %0h", res_m, 24'd70); end
      step();
   endtask

   task automatic test_drain_hold();
      logic [7:0][7:0] va, vb;
      bit res_bad, vld_bad, rdy_bad, ci_bad;
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
         va[i] = 8'(i);
         vb[i] = 8'd1;
      end
      res_ready = 1'b0;
      send_vec(va, vb, 0);
      wait_result();
      checks++; if (res_m !== 24'd100) begin errors++; $display("FAIL hold_res got %0h want %0h", res_m, 24'd100); end
      in_valid = 1'b1;
      in_a = 8'h55;
      in_b = 8'h66;
      {res_bad, vld_bad, rdy_bad, ci_bad} = '0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (res_m !== 24'd100) res_bad = 1'b1;
         if (res_valid_m !== 1'b1) vld_bad = 1'b1;
         if (in_ready_m !== 1'b0) rdy_bad = 1'b1;
         if (ci0_m !== va || ci1_m !== vb) ci_bad = 1'b1;
      end
      checks++; if (res_bad) begin errors++; $display("FAIL hold_res_stable got %0h want %0h", res_m, 24'd100); end
      checks++; if (vld_bad) begin errors++; $display("FAIL hold_valid_stable got %0b want 1", res_valid_m); end
      checks++; if (rdy_bad) begin errors++; $display("FAIL hold_in_ready got %0b want 0", in_ready_m); end
      checks++; if (ci_bad) begin errors++; $display("FAIL hold_core_in got %0h want %0h", ci0_m, va); end
      in_valid = 1'b0;
      res_ready = 1'b1;
      step();
      checks++; if (res_valid_m !== 1'b0) begin errors++; $display("FAIL release_valid got %0b want 0", res_valid_m); end
      checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", in_ready_m); end
   endtask

   task automatic test_reset_mid();
      logic [7:0][7:0] va, vb;
      pulse_reset();
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_beat(8'd9, 8'd9, 0);
      pulse_reset();
      checks++; if (ci0_m !== '0) begin errors++; $display("FAIL midfill_discard got %0h want 0", ci0_m); end
      run_directed("after_rst", 8'd1, 8'd1, 24'd16);
      fill_vec(va, vb, 8'd1, 8'd1);
      res_ready = 1'b0;
      send_vec(va, vb, 0);
      wait_result();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (res_valid_m !== 1'b0) begin errors++; $display("FAIL drain_rst_valid got %0b want 0", res_valid_m); end
      checks++; if (res_m !== '0) begin errors++; $display("FAIL drain_rst_res got %0h want 0", res_m); end
      checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL drain_rst_in_ready got %0b want 1", in_ready_m); end
      res_ready = 1'b1;
   endtask

   task automatic test_latency();
      logic [7:0][7:0] va, vb;
      int n1, n3, n5;
      pulse_reset();
      res_ready = 1'b0;
      fill_vec(va, vb, 8'd1, 8'd1);
      send_vec(va, vb, 0);
      n1 = -1; n3 = -1; n5 = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (res_valid_1 && n1 < 0) n1 = k;
         if (res_valid_m && n3 < 0) n3 = k;
         if (res_valid_5 && n5 < 0) n5 = k;
      end
      checks++; if (n1 != 1) begin errors++; $display("FAIL lat1_capture got %0d want 1", n1); end
      checks++; if (n3 != 3) begin errors++; $display("FAIL lat3_capture got %0d want 3", n3); end
      checks++; if (n5 != 5) begin errors++; $display("FAIL lat5_capture got %0d want 5", n5); end
      checks++; if (res_1 !== 24'd16) begin errors++; $display("FAIL lat1_res got %0h want %0h", res_1, 24'd16); end
      checks++; if (res_5 !== 24'd16) begin errors++; $display("FAIL lat5_res got %0h want %0h", res_5, 24'd16); end
      res_ready = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [7:0][7:0] va, vb;
      logic [OW-1:0] exp;
      int bad_lat, bad_rdy;
      pulse_reset();
      res_ready = 1'b1;
      bad_lat = 0;
      bad_rdy = 0;
      for (int v = 0; v < 100; v++) begin
         for (int i = 0; i < 8; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
         end
         exp = psum(va, vb, 0) + psum(va, vb, 4);
         send_vec(va, vb, 3);
         wait_result();
         if (lat_n != 3) bad_lat++;
         if (ready_bad) bad_rdy++;
         checks++;
         if (res_m !== exp) begin
            errors++;
            $display("FAIL rand_res vec %0d got %0h want %0h", v, res_m, exp);
         end
         step();
      end
      checks++; if (bad_lat != 0) begin errors++; $display("FAIL rand_latency bad vectors %0d want 0", bad_lat); end
      checks++; if (bad_rdy != 0) begin errors++; $display("FAIL rand_ready_in_wait bad vectors %0d want 0", bad_rdy); end
   endtask

   initial begin
      test_reset();
      test_ones();
      test_neg();
      test_wrap();
      test_fill_hold();
      test_drain_hold();
      test_reset_mid();
      test_latency();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
